// File: rtl/onchip_memory_dual_slave.sv
// onchip_memory_dual_slave: dual-port on-chip RAM with two Avalon-style slaves
// Ports: clk/reset (sync, active-high), clken and reset_req freeze the block;
// per slave p in {s1,s2}: address, chipselect, read, write, byteenable, writedata in;
// readdata, readdatavalid, waitrequest out. Same-address conflicts involving a write
// are arbitrated by a priority bit that alternates after every conflict cycle.
module onchip_memory_dual_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int READ_LATENCY = 1,
  parameter string INIT_FILE = "onchip_memory_dual_slave.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest
);
  localparam int NB = DATA_WIDTH / 8;
  logic [1:0] req, wr, acc, rd;
  logic [ADDR_WIDTH-1:0] addr [2];
  logic [NB-1:0] be [2];
  logic [DATA_WIDTH-1:0] wdata [2];
  logic active, conflict, prio;
  (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [READ_LATENCY-1:0] vld [2];
  logic [DATA_WIDTH-1:0] dat [2][READ_LATENCY];
  assign addr[0] = s1_address;
  assign addr[1] = s2_address;
  assign be[0] = s1_byteenable;
  assign be[1] = s2_byteenable;
  assign wdata[0] = s1_writedata;
  assign wdata[1] = s2_writedata;
  assign req = {s2_chipselect & (s2_read | s2_write), s1_chipselect & (s1_read | s1_write)};
  assign wr = {s2_write, s1_write};
  // reset is folded in so nothing is accepted during the reset cycle
  assign active = clken & ~reset_req & ~reset;
  assign conflict = &req & (addr[0] == addr[1]) & |wr;
  // prio = 0: s1 wins a conflict, prio = 1: s2 wins
  assign s1_waitrequest = ~active | (conflict & prio);
  assign s2_waitrequest = ~active | (conflict & ~prio);
  assign acc = req & ~{s2_waitrequest, s1_waitrequest};
  assign rd = acc & ~wr;
  always_ff @(posedge clk)
    if (reset) prio <= 1'b0;
    else if (active && conflict) prio <= ~prio;
  // memory is deliberately not reset; reads in the pipeline block see pre-write data
  always_ff @(posedge clk)
    for (int p = 0; p < 2; p++)
      for (int b = 0; b < NB; b++)
        if (acc[p] && wr[p] && be[p][b]) mem[addr[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
  // read pipeline advances only on active cycles; data stages load only behind a valid so readdata holds
  always_ff @(posedge clk)
    for (int p = 0; p < 2; p++)
      if (reset) begin
        vld[p] <= '0;
        for (int i = 0; i < READ_LATENCY; i++) dat[p][i] <= '0;
      end else if (active) begin
        vld[p][0] <= rd[p];
        if (rd[p]) dat[p][0] <= mem[addr[p]];
        for (int i = 1; i < READ_LATENCY; i++) begin
          vld[p][i] <= vld[p][i-1];
          if (vld[p][i-1]) dat[p][i] <= dat[p][i-1];
        end
      end
  assign s1_readdatavalid = vld[0][READ_LATENCY-1];
  assign s2_readdatavalid = vld[1][READ_LATENCY-1];
  assign s1_readdata = dat[0][READ_LATENCY-1];
  assign s2_readdata = dat[1][READ_LATENCY-1];
endmodule

// File: tb/tb_onchip_memory_dual_slave.sv
// tb_onchip_memory_dual_slave: directed table, corner sequences and random traffic on latency-1 and latency-2 instances
module tb_onchip_memory_dual_slave;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, clken, reset_req;
  logic s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
  logic [13:0] s1_address, s2_address;
  logic [3:0] s1_byteenable, s2_byteenable;
  logic [31:0] s1_writedata, s2_writedata;
  logic [31:0] rdo [4];
  logic [3:0] rv, wq;
  int tests = 0, fails = 0;
  onchip_memory_dual_slave #(.READ_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
    .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(rdo[0]), .s1_readdatavalid(rv[0]), .s1_waitrequest(wq[0]),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
    .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(rdo[1]), .s2_readdatavalid(rv[1]), .s2_waitrequest(wq[1]));
  onchip_memory_dual_slave #(.READ_LATENCY(2)) u2 (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
    .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(rdo[2]), .s1_readdatavalid(rv[2]), .s1_waitrequest(wq[2]),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
    .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(rdo[3]), .s2_readdatavalid(rv[3]), .s2_waitrequest(wq[3]));
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask
  // reference model: flat word array, per-output queue of reads stamped with the active-cycle count when due
  typedef struct { logic [31:0] d; int due; } rd_t;
  rd_t q [4][$];
  logic [31:0] mem_m [16384];
  logic [31:0] exp_d [4];
  int act_cnt = 0;
  int prio = 0;
  task automatic model_step();
    logic act, conf;
    logic [1:0] r, w, acc;
    logic [13:0] a [2];
    logic [3:0] b [2];
    logic [31:0] wd [2], mask, rdat [2];
    logic [3:0] vis;
    rd_t e;
    a[0] = s1_address; a[1] = s2_address;
    b[0] = s1_byteenable; b[1] = s2_byteenable;
    wd[0] = s1_writedata; wd[1] = s2_writedata;
    r = {s2_chipselect & (s2_read | s2_write), s1_chipselect & (s1_read | s1_write)};
    w = {s2_write, s1_write};
    act = clken & ~reset_req & ~reset;
    conf = r[0] & r[1] & (a[0] == a[1]) & (w[0] | w[1]);
    for (int p = 0; p < 2; p++) begin
      acc[p] = act & r[p] & !(conf && prio != p);
      for (int u = 0; u < 2; u++)
        chk($sformatf("wait_u%0d_s%0d", u + 1, p + 1), 32'(wq[u*2+p]), 32'(!act || (conf && prio != p)));
    end
    for (int k = 0; k < 4; k++) begin
      vis[k] = q[k].size() > 0 && q[k][0].due == act_cnt;
      if (vis[k]) exp_d[k] = q[k][0].d;
      chk($sformatf("valid_u%0d_s%0d", k / 2 + 1, k % 2 + 1), 32'(rv[k]), 32'(vis[k]));
      chk($sformatf("rdata_u%0d_s%0d", k / 2 + 1, k % 2 + 1), rdo[k], exp_d[k]);
    end
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        q[k].delete();
        exp_d[k] = '0;
      end
      prio = 0;
    end else if (act) begin
      for (int k = 0; k < 4; k++) if (vis[k]) void'(q[k].pop_front());
      for (int p = 0; p < 2; p++) rdat[p] = mem_m[a[p]];
      for (int p = 0; p < 2; p++)
        if (acc[p] && !w[p])
          for (int l = 1; l <= 2; l++) begin
            e.d = rdat[p];
            e.due = act_cnt + l;
            q[(l - 1) * 2 + p].push_back(e);
          end
        else if (acc[p]) begin
          mask = {{8{b[p][3]}}, {8{b[p][2]}}, {8{b[p][1]}}, {8{b[p][0]}}};
          mem_m[a[p]] = (mem_m[a[p]] & ~mask) | (wd[p] & mask);
        end
      if (conf) prio = 1 - prio;
      act_cnt++;
    end
  endtask
  task automatic go();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    {reset, clken, reset_req} = 3'b010;
    {s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write} = '0;
    s1_address = '0; s2_address = '0;
    s1_byteenable = 4'hF; s2_byteenable = 4'hF;
    s1_writedata = '0; s2_writedata = '0;
  endtask
  typedef struct {
    logic [2:0] ctl;
    logic [1:0] o1, o2;
    logic [13:0] a1, a2;
    logic [3:0] b1, b2;
    logic [31:0] w1, w2;
    logic [1:0] ew, ev;
    logic [31:0] ed1, ed2;
  } vec_t;
  function automatic vec_t mk(logic [2:0] ctl, logic [1:0] o1, logic [13:0] a1, logic [3:0] b1, logic [31:0] w1,
                              logic [1:0] o2, logic [13:0] a2, logic [3:0] b2, logic [31:0] w2,
                              logic [1:0] ew, logic [1:0] ev, logic [31:0] ed1, logic [31:0] ed2);
    vec_t v;
    v.ctl = ctl; v.o1 = o1; v.a1 = a1; v.b1 = b1; v.w1 = w1;
    v.o2 = o2; v.a2 = a2; v.b2 = b2; v.w2 = w2;
    v.ew = ew; v.ev = ev; v.ed1 = ed1; v.ed2 = ed2;
    return v;
  endfunction
  task automatic apply(vec_t v);
    {reset, clken, reset_req} = v.ctl;
    s1_chipselect = |v.o1; {s1_write, s1_read} = v.o1;
    s2_chipselect = |v.o2; {s2_write, s2_read} = v.o2;
    s1_address = v.a1; s1_byteenable = v.b1; s1_writedata = v.w1;
    s2_address = v.a2; s2_byteenable = v.b2; s2_writedata = v.w2;
  endtask
  localparam logic [2:0] N = 3'b010;
  localparam logic [1:0] I = 2'd0, R = 2'd1, W = 2'd2, RW = 2'd3;
  vec_t tbl [28];
  initial begin
    #2_000_000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end
  initial begin
    int nv;
    tbl[0]  = mk(N, W, 14'h10, 4'hF, 32'hA5A5A5A5, I, 0, 4'hF, 0, 2'b00, 2'b00, 0, 0);
    tbl[1]  = mk(N, I, 0, 4'hF, 0, R, 14'h10, 4'hF, 0, 2'b00, 2'b00, 0, 0);
    tbl[2]  = mk(N, I, 0, 4'hF, 0, I, 0, 4'hF, 0, 2'b00, 2'b10, 0, 32'hA5A5A5A5);
    tbl[3]  = mk(N, W, 5, 4'hF, 32'h11223344, W, 5, 4'hF, 32'hFFFFFFFF, 2'b10, 2'b00, 0, 0);
    tbl[4]  = mk(N, I, 0, 4'hF, 0, RW, 5, 4'hF, 32'hFFFFFFFF, 2'b00, 2'b00, 0, 0);
    tbl[5]  = mk(N, R, 5, 4'hF, 0, I, 0, 4'hF, 0, 2'b00, 2'b00, 0, 0);
    tbl[6]  = mk(N, I, 0, 4'hF, 0, I, 0, 4'hF, 0, 2'b00, 2'b01, 32'hFFFFFFFF, 0);
    tbl[7]  = mk(N, W, 5, 4'hF, 32'hAAAAAAAA, R, 5, 4'hF, 0, 2'b01, 2'b00, 0, 0);
    tbl[8]  = mk(N, W, 5, 4'hF, 32'hAAAAAAAA, R, 5, 4'hF, 0, 2'b10, 2'b10, 0, 32'hFFFFFFFF);
    tbl[9]  = mk(N, I, 0, 4'hF, 0, R, 5, 4'hF, 0, 2'b00, 2'b00, 0, 0);
    tbl[10] = mk(N, I, 0, 4'hF, 0, I, 0, 4'hF, 0, 2'b00, 2'b10, 0, 32'hAAAAAAAA);
    tbl[11] = mk(N, W, 7, 4'b0101, 32'hDEADBEEF, I, 0, 4'hF, 0, 2'b00, 2'b00, 0, 0);
    tbl[12] = mk(N, R, 7, 4'hF, 0, I, 0, 4'hF, 0, 2'b00, 2'b00, 0, 0);
    tbl[13] = mk(N, I, 0, 4'hF, 0, I, 0, 4'hF, 0, 2'b00, 2'b01, 32'h00AD00EF, 0);
    tbl[14] = mk(N, W, 14'h3FFF, 4'hF, 32'h12345678, I, 0, 4'hF, 0, 2'b00, 2'b00, 0, 0);
    tbl[15] = mk(N, R, 14'h3FFF, 4'hF, 0, R, 14'h3FFF, 4'hF, 0, 2'b00, 2'b00, 0, 0);
    tbl[16] = mk(N, I, 0, 4'hF, 0, I, 0, 4'hF, 0, 2'b00, 2'b11, 32'h12345678, 32'h12345678);
    tbl[17] = mk(N, W, 14'h3FFF, 4'h0, 32'hFFFFFFFF, I, 0, 4'hF, 0, 2'b00, 2'b00, 0, 0);
    tbl[18] = mk(N, I, 0, 4'hF, 0, R, 14'h3FFF, 4'hF, 0, 2'b00, 2'b00, 0, 0);
    tbl[19] = mk(N, I, 0, 4'hF, 0, I, 0, 4'hF, 0, 2'b00, 2'b10, 0, 32'h12345678);
    tbl[20] = mk(3'b000, R, 0, 4'hF, 0, I, 0, 4'hF, 0, 2'b11, 2'b00, 0, 0);
    tbl[21] = mk(3'b011, I, 0, 4'hF, 0, W, 0, 4'hF, 32'h12, 2'b11, 2'b00, 0, 0);
    tbl[22] = mk(N, I, 0, 4'hF, 0, I, 0, 4'hF, 0, 2'b00, 2'b00, 0, 0);
    tbl[23] = mk(3'b110, W, 0, 4'hF, 32'h0BAD, I, 0, 4'hF, 0, 2'b11, 2'b00, 0, 0);
    tbl[24] = mk(N, R, 0, 4'hF, 0, I, 0, 4'hF, 0, 2'b00, 2'b00, 0, 0);
    tbl[25] = mk(N, I, 0, 4'hF, 0, I, 0, 4'hF, 0, 2'b00, 2'b01, 0, 0);
    tbl[26] = mk(N, W, 1, 4'hF, 32'h1111, W, 1, 4'hF, 32'h2222, 2'b10, 2'b00, 0, 0);
    tbl[27] = mk(N, I, 0, 4'hF, 0, I, 0, 4'hF, 0, 2'b00, 2'b00, 0, 0);
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    go();
    reset = 1'b0;
    for (int i = 0; i < 33; i++) begin
      s1_chipselect = 1'b1; s1_write = 1'b1;
      s1_address = i == 32 ? 14'h3FFF : 14'(i);
      go();
    end
    idle();
    for (int i = 0; i < 28; i++) begin
      apply(tbl[i]);
      @(negedge clk);
      chk($sformatf("tbl%0d_wait", i), 32'({wq[1], wq[0]}), 32'(tbl[i].ew));
      chk($sformatf("tbl%0d_valid", i), 32'({rv[1], rv[0]}), 32'(tbl[i].ev));
      if (tbl[i].ev[0]) chk($sformatf("tbl%0d_rdata1", i), rdo[0], tbl[i].ed1);
      if (tbl[i].ev[1]) chk($sformatf("tbl%0d_rdata2", i), rdo[1], tbl[i].ed2);
      model_step();
      @(posedge clk);
      #1;
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      s1_chipselect = 1'b1; s1_write = 1'b1;
      s1_address = 14'(i); s1_writedata = 32'hC0DE0000 + i;
      go();
    end
    idle();
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      idle();
      if (c < 5) begin
        s1_chipselect = 1'b1; s1_read = 1'b1;
        s1_address = c < 2 ? 14'(c) : 14'd2;
      end
      clken = !(c == 2 || c == 3);
      @(negedge clk);
      if (!clken) chk("freeze_wait_u2", 32'(wq[2]), 32'd1);
      if (clken && rv[2]) begin
        chk("stretch_cycle", c, 4 + nv);
        chk("stretch_data", rdo[2], 32'hC0DE0000 + nv);
        nv++;
      end
      model_step();
      @(posedge clk);
      #1;
    end
    chk("stretch_count", nv, 3);
    for (int c = 0; c < 5; c++) begin
      idle();
      if (c == 0) begin
        s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = 14'h10;
      end
      reset = c == 1;
      @(negedge clk);
      if (c >= 2) begin
        chk("rst_drop_valid", 32'({rv[2], rv[0]}), 0);
        chk("rst_rdata_u1", rdo[0], 0);
        chk("rst_rdata_u2", rdo[2], 0);
      end
      model_step();
      @(posedge clk);
      #1;
    end
    idle();
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = 14'h10;
    go();
    idle();
    @(negedge clk);
    chk("post_rst_valid_u1", 32'(rv[0]), 1);
    chk("post_rst_data_u1", rdo[0], 32'hA5A5A5A5);
    model_step();
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_rst_data_u2", rdo[2], 32'hA5A5A5A5);
    model_step();
    @(posedge clk);
    #1;
    for (int c = 0; c < 600; c++) begin
      reset = $urandom_range(0, 63) == 0;
      clken = $urandom_range(0, 15) != 0;
      reset_req = $urandom_range(0, 31) == 0;
      s1_chipselect = $urandom_range(0, 3) != 0;
      s1_read = 1'($urandom); s1_write = 1'($urandom);
      s1_address = $urandom_range(0, 7) == 0 ? 14'h3FFF : 14'($urandom_range(0, 3));
      s1_byteenable = 4'($urandom); s1_writedata = $urandom;
      s2_chipselect = $urandom_range(0, 3) != 0;
      s2_read = 1'($urandom); s2_write = 1'($urandom);
      s2_address = $urandom_range(0, 7) == 0 ? 14'h3FFF : 14'($urandom_range(0, 3));
      s2_byteenable = 4'($urandom); s2_writedata = $urandom;
      go();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
